// File: rtl/coproc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coproc_pkg
// Purpose  : Shared definitions for the matrix coprocessor controller:
//            opcode encodings, FSM state encodings, instruction field
//            positions and the matrix-size helper.
// Revision : 1.0 - initial release
// ============================================================================
package coproc_pkg;

  // Opcodes; 0x0, 0xE and 0xF are illegal
  localparam logic [3:0] c_op_load      = 4'h1;
  localparam logic [3:0] c_op_write     = 4'h2;
  localparam logic [3:0] c_op_alu_first = 4'h3;  // SUM
  localparam logic [3:0] c_op_alu_last  = 4'hC;  // DET5
  localparam logic [3:0] c_op_store     = 4'hD;

  // Controller states
  typedef logic [2:0] state_t;
  localparam state_t c_st_idle   = 3'd0;
  localparam state_t c_st_decode = 3'd1;
  localparam state_t c_st_mem_wr = 3'd2;
  localparam state_t c_st_load   = 3'd3;
  localparam state_t c_st_exec   = 3'd4;
  localparam state_t c_st_store  = 3'd5;

  // Instruction word fields; bits [31:28] are reserved and ignored
  localparam int c_op_lsb   = 0;
  localparam int c_op_w     = 4;
  localparam int c_addr_lsb = 4;
  localparam int c_addr_w   = 8;
  localparam int c_data_lsb = 12;
  localparam int c_data_w   = 16;

  // Elements per DIM x DIM matrix
  function automatic int n2(input int dim);
    return dim * dim;
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= c_op_alu_first) && (op <= c_op_alu_last);
  endfunction

endpackage
`default_nettype wire

// File: rtl/coproc_if.sv
`default_nettype none
// ============================================================================
// Module   : coproc_if
// Purpose  : Bundle of the controller's instruction, memory, operand-bank and
//            ALU signals.
//            slave  : controller view (accepts instructions, drives memory/ALU)
//            master : environment view (host, memory, ALU datapath)
// Ports    : instr_valid/instr_ready/instr      instruction handshake
//            mem_req/we/addr/wdata/rdata/ack     single-element memory port
//            mat_a/mat_b (out), mat_c (in)       packed DIM x DIM matrices
//            alu_start/op/scalar/done            ALU dispatch
//            busy/loaded/err                     status
// Revision : 1.0 - initial release
// ============================================================================
interface coproc_if #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5,
  parameter int ADDR_W = 8
);
  import coproc_pkg::*;

  localparam int N2 = n2(DIM);

  logic                   instr_valid;
  logic                   instr_ready;
  logic [31:0]            instr;
  logic                   mem_req;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [ELEM_W-1:0]      mem_wdata;
  logic [ELEM_W-1:0]      mem_rdata;
  logic                   mem_ack;
  logic [N2*ELEM_W-1:0]   mat_a;
  logic [N2*ELEM_W-1:0]   mat_b;
  logic [N2*ELEM_W-1:0]   mat_c;
  logic                   alu_start;
  logic [3:0]             alu_op;
  logic [15:0]            alu_scalar;
  logic                   alu_done;
  logic                   busy;
  logic                   loaded;
  logic                   err;

  modport slave (
    input  instr_valid, instr, mem_rdata, mem_ack, mat_c, alu_done,
    output instr_ready, mem_req, mem_we, mem_addr, mem_wdata,
           mat_a, mat_b, alu_start, alu_op, alu_scalar, busy, loaded, err
  );

  modport master (
    output instr_valid, instr, mem_rdata, mem_ack, mat_c, alu_done,
    input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata,
           mat_a, mat_b, alu_start, alu_op, alu_scalar, busy, loaded, err
  );

endinterface
`default_nettype wire

// File: rtl/coproc_ctrl_operand_bank.sv
`default_nettype none
// ============================================================================
// Module   : operand_bank
// Purpose  : Two DIM x DIM element register arrays (operands A and B) with a
//            single indexed write port and asynchronous clear.
// Ports    : clk, rst       clock, async active-high clear
//            we, sel_b      write enable, 0 = bank A / 1 = bank B
//            idx, wdata     element index (row*DIM+col) and data
//            mat_a, mat_b   packed contents, element k at [k*ELEM_W +: ELEM_W]
// Revision : 1.0 - initial release
// ============================================================================
module operand_bank #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic                          sel_b,
  input  logic [$clog2(DIM*DIM)-1:0]    idx,
  input  logic [ELEM_W-1:0]             wdata,
  output logic [DIM*DIM*ELEM_W-1:0]     mat_a,
  output logic [DIM*DIM*ELEM_W-1:0]     mat_b
);

  localparam int N2 = DIM * DIM;

  logic [ELEM_W-1:0] r_a [N2];
  logic [ELEM_W-1:0] r_b [N2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N2; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
    end else if (we) begin
      if (sel_b) r_b[idx] <= wdata;
      else       r_a[idx] <= wdata;
    end
  end

  for (genvar k = 0; k < N2; k++) begin : g_pack
    assign mat_a[k*ELEM_W +: ELEM_W] = r_a[k];
    assign mat_b[k*ELEM_W +: ELEM_W] = r_b[k];
  end

endmodule
`default_nettype wire

// File: rtl/coproc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : coproc_ctrl
// Purpose  : Matrix coprocessor control unit. Accepts 32-bit instructions and
//            sequences single writes, A/B burst loads into the operand bank,
//            ALU dispatch and write-back of the result matrix C.
// Ports    : clk  clock
//            rst  asynchronous active-high reset
//            bus  coproc_if.slave (instruction, memory, matrix, ALU, status)
// Revision : 1.0 - initial release
// ============================================================================
module coproc_ctrl
  import coproc_pkg::*;
#(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5,
  parameter int ADDR_W = 8
) (
  input  logic    clk,
  input  logic    rst,
  coproc_if.slave bus
);

  localparam int N2    = n2(DIM);
  localparam int IDX_W = $clog2(N2);
  localparam int CNT_W = $clog2(2*N2 + 1);

  localparam logic [CNT_W-1:0] c_load_total  = CNT_W'(2*N2);
  localparam logic [CNT_W-1:0] c_store_total = CNT_W'(N2);
  localparam logic [CNT_W-1:0] c_write_total = CNT_W'(1);

  state_t              r_state;
  logic [3:0]          r_op;
  logic [ADDR_W-1:0]   r_base;
  logic [15:0]         r_data;
  logic [CNT_W-1:0]    r_cnt;      // completed transfers in the current burst
  logic                r_req;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [ELEM_W-1:0]   r_wdata;
  logic                r_start;
  logic [3:0]          r_alu_op;
  logic [15:0]         r_alu_scalar;
  logic                r_loaded;
  logic                r_err;

  logic                w_legal;
  logic [CNT_W-1:0]    w_total;
  logic                w_bank_we;
  logic                w_sel_b;
  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_cnt_idx;
  logic [ELEM_W-1:0]   w_c_elem [N2];
  logic                w_unused_rsvd;

  assign w_unused_rsvd = ^bus.instr[31:28];

  assign w_legal = (r_op == c_op_load) || (r_op == c_op_write) ||
                   (r_op == c_op_store) || is_alu_op(r_op);

  assign w_total = (r_state == c_st_store)  ? c_store_total :
                   (r_state == c_st_mem_wr) ? c_write_total : c_load_total;

  // A and B are fetched as one contiguous 2*N2 burst: the count selects the bank
  assign w_sel_b   = (r_cnt >= CNT_W'(N2));
  assign w_idx     = IDX_W'(w_sel_b ? (r_cnt - CNT_W'(N2)) : r_cnt);
  assign w_bank_we = (r_state == c_st_load) && r_req && bus.mem_ack;
  assign w_cnt_idx = IDX_W'(r_cnt);

  for (genvar k = 0; k < N2; k++) begin : g_c_unpack
    assign w_c_elem[k] = bus.mat_c[k*ELEM_W +: ELEM_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_op         <= '0;
      r_base       <= '0;
      r_data       <= '0;
      r_cnt        <= '0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_start      <= 1'b0;
      r_alu_op     <= '0;
      r_alu_scalar <= '0;
      r_loaded     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (bus.instr_valid) begin
            r_op    <= bus.instr[c_op_lsb +: c_op_w];
            r_base  <= ADDR_W'(bus.instr[c_addr_lsb +: c_addr_w]);
            r_data  <= bus.instr[c_data_lsb +: c_data_w];
            r_state <= c_st_decode;
          end
        end

        // Issues the first transfer directly so mem_req rises right after
        c_st_decode: begin
          r_cnt <= '0;
          if (!w_legal) begin
            r_err   <= 1'b1;
            r_state <= c_st_idle;
          end else begin
            r_err <= 1'b0;
            if (r_op == c_op_write) begin
              r_req   <= 1'b1;
              r_we    <= 1'b1;
              r_addr  <= r_base;
              r_wdata <= r_data[ELEM_W-1:0];
              r_state <= c_st_mem_wr;
            end else if (r_op == c_op_load) begin
              r_req   <= 1'b1;
              r_we    <= 1'b0;
              r_addr  <= r_base;
              r_state <= c_st_load;
            end else if (r_op == c_op_store) begin
              r_req   <= 1'b1;
              r_we    <= 1'b1;
              r_addr  <= r_base;
              r_wdata <= w_c_elem[0];
              r_state <= c_st_store;
            end else begin
              r_alu_op     <= r_op;
              r_alu_scalar <= r_data;
              if (r_loaded) begin
                r_start <= 1'b1;
                r_state <= c_st_exec;
              end else begin
                // Operands missing: implicit load from address 0 first
                r_base  <= '0;
                r_req   <= 1'b1;
                r_we    <= 1'b0;
                r_addr  <= '0;
                r_state <= c_st_load;
              end
            end
          end
        end

        // Shared burst engine: request held until ack, then one idle cycle
        // in which either the next transfer is issued or the burst retires.
        c_st_mem_wr, c_st_load, c_st_store: begin
          if (r_req) begin
            if (bus.mem_ack) begin
              r_req <= 1'b0;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else if (r_cnt == w_total) begin
            case (r_state)
              c_st_mem_wr: begin
                r_loaded <= 1'b0;
                r_state  <= c_st_idle;
              end
              c_st_load: begin
                r_loaded <= 1'b1;
                if (r_op == c_op_load) begin
                  r_state <= c_st_idle;
                end else begin
                  r_start <= 1'b1;
                  r_state <= c_st_exec;
                end
              end
              default: r_state <= c_st_idle;
            endcase
          end else begin
            r_req  <= 1'b1;
            r_addr <= r_base + ADDR_W'(r_cnt);
            if (r_state == c_st_store) r_wdata <= w_c_elem[w_cnt_idx];
          end
        end

        c_st_exec: begin
          if (bus.alu_done) begin
            r_start <= 1'b0;
            r_state <= c_st_idle;
          end
        end

        default: r_state <= c_st_idle;
      endcase
    end
  end

  operand_bank #(
    .ELEM_W (ELEM_W),
    .DIM    (DIM)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (w_bank_we),
    .sel_b  (w_sel_b),
    .idx    (w_idx),
    .wdata  (bus.mem_rdata),
    .mat_a  (bus.mat_a),
    .mat_b  (bus.mat_b)
  );

  assign bus.instr_ready = (r_state == c_st_idle) && !rst;
  assign bus.mem_req     = r_req;
  assign bus.mem_we      = r_we;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wdata   = r_wdata;
  assign bus.alu_start   = r_start;
  assign bus.alu_op      = r_alu_op;
  assign bus.alu_scalar  = r_alu_scalar;
  assign bus.busy        = (r_state != c_st_idle);
  assign bus.loaded      = r_loaded;
  assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_coproc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_coproc_ctrl
// Purpose  : Self-checking bench for coproc_ctrl (DIM=5, memory latency 1,
//            ALU latency 7). Expected memory transfers and ALU dispatches are
//            queued by the stimulus; a responder process models memory and
//            ALU and checks every transfer/dispatch against the queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coproc_ctrl;
  import coproc_pkg::*;

  localparam int ELEM_W  = 8;
  localparam int DIM     = 5;
  localparam int ADDR_W  = 8;
  localparam int N2      = DIM * DIM;
  localparam int MW      = N2 * ELEM_W;
  localparam int LAT     = 1;
  localparam int ALU_DLY = 7;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } xfer_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] sc;
  } alu_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    pat = 0;
  int    hic = 0;
  int    acnt = 0;
  xfer_t exp_mem[$];
  alu_t  exp_alu[$];
  xfer_t me;
  alu_t  ae;

  coproc_if #(.ELEM_W(ELEM_W), .DIM(DIM), .ADDR_W(ADDR_W)) bus ();

  coproc_ctrl #(.ELEM_W(ELEM_W), .DIM(DIM), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic logic [7:0] mem_val(input logic [7:0] a);
    return (pat == 0) ? a : (a ^ 8'h5A);
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [7:0] a, input logic [15:0] d);
    return {4'hA, d, a, op};  // reserved nibble deliberately non-zero
  endfunction

  // Memory and ALU responder plus scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      bus.alu_done  = 1'b0;
      hic  = 0;
      acnt = 0;
    end else begin
      if (bus.mem_req) begin
        hic++;
        if (hic == LAT) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_val(bus.mem_addr);
          if (exp_mem.size() == 0) begin
            note_fail("mem_xfer", $sformatf("unexpected we=%b addr=%0h wdata=%0h, required none",
                      bus.mem_we, bus.mem_addr, bus.mem_wdata));
          end else begin
            me = exp_mem.pop_front();
            chk("mem_we", bus.mem_we, me.we);
            chk("mem_addr", bus.mem_addr, me.addr);
            if (me.we) chk("mem_wdata", bus.mem_wdata, me.wdata);
          end
        end else begin
          bus.mem_ack = 1'b0;
        end
      end else begin
        hic = 0;
        bus.mem_ack = 1'b0;
      end

      if (bus.alu_start) begin
        acnt++;
        if (acnt == 1) begin
          if (exp_alu.size() == 0) begin
            note_fail("alu_start", $sformatf("unexpected op=%0h, required none", bus.alu_op));
          end else begin
            ae = exp_alu.pop_front();
            chk("alu_op", bus.alu_op, ae.op);
            chk("alu_scalar", bus.alu_scalar, ae.sc);
          end
        end
        bus.alu_done = (acnt == ALU_DLY);
      end else begin
        acnt = 0;
        bus.alu_done = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] word, output int t_acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) note_fail("instr_ready_wait", "timeout, required ready");
    t_acc = cyc;
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("instr_ready_drop", bus.instr_ready, 1'b0);
  endtask

  task automatic wait_idle(output int t);
    int n;
    n = 0;
    while (bus.busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) note_fail("idle_wait", "timeout, required busy=0");
    t = cyc;
    chk("idle_ready", bus.instr_ready, 1'b1);
  endtask

  task automatic push_load(input logic [7:0] base);
    for (int i = 0; i < 2*N2; i++) exp_mem.push_back(xfer_t'{1'b0, 8'(base + 8'(i)), 8'h00});
  endtask

  task automatic check_bank(input string name, input logic [7:0] base);
    logic [MW-1:0] ea, eb;
    for (int k = 0; k < N2; k++) begin
      ea[k*ELEM_W +: ELEM_W] = mem_val(8'(base + 8'(k)));
      eb[k*ELEM_W +: ELEM_W] = mem_val(8'(base + 8'(N2 + k)));
    end
    chk({name, "_mat_a"}, bus.mat_a, ea);
    chk({name, "_mat_b"}, bus.mat_b, eb);
  endtask

  task automatic drained(input string name);
    chk({name, "_mem_left"}, exp_mem.size(), 0);
    chk({name, "_alu_left"}, exp_alu.size(), 0);
  endtask

  initial begin
    int t_a, t_i;
    logic found;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.mat_c       = '0;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_instr_ready_low", bus.instr_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_instr_ready", bus.instr_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 8'h00);
    chk("rst_mem_wdata", bus.mem_wdata, 8'h00);
    chk("rst_alu_start", bus.alu_start, 1'b0);
    chk("rst_alu_op", bus.alu_op, 4'h0);
    chk("rst_alu_scalar", bus.alu_scalar, 16'h0);
    chk("rst_loaded", bus.loaded, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_mat_a", bus.mat_a, '0);
    chk("rst_mat_b", bus.mat_b, '0);

    // WRITE 0x10 <= 0xAB
    exp_mem.push_back(xfer_t'{1'b1, 8'h10, 8'hAB});
    send(mk(c_op_write, 8'h10, 16'h00AB), t_a);
    wait_idle(t_i);
    chk("write_latency", t_i - t_a, 4);
    chk("write_loaded", bus.loaded, 1'b0);
    drained("write");

    // LOAD base 0, memory[i] = i
    pat = 0;
    push_load(8'h00);
    send(mk(c_op_load, 8'h00, 16'h0000), t_a);
    wait_idle(t_i);
    chk("load_latency", t_i - t_a, 2 + 2*N2*(LAT+1));
    chk("load_loaded", bus.loaded, 1'b1);
    check_bank("load", 8'h00);
    drained("load");

    // WRITE clears loaded; data truncated to the element width
    exp_mem.push_back(xfer_t'{1'b1, 8'h60, 8'h34});
    send(mk(c_op_write, 8'h60, 16'h1234), t_a);
    wait_idle(t_i);
    chk("write2_loaded", bus.loaded, 1'b0);
    drained("write2");

    // SUM with nothing loaded: implicit LOAD from 0, then ALU
    pat = 1;
    push_load(8'h00);
    exp_alu.push_back(alu_t'{4'h3, 16'h0005});
    send(mk(4'h3, 8'h77, 16'h0005), t_a);
    wait_idle(t_i);
    chk("sum_latency", t_i - t_a, 2 + 2*N2*(LAT+1) + ALU_DLY);
    chk("sum_loaded", bus.loaded, 1'b1);
    chk("sum_alu_op", bus.alu_op, 4'h3);
    chk("sum_alu_start_low", bus.alu_start, 1'b0);
    check_bank("sum", 8'h00);
    drained("sum");

    // SUB with operands loaded: straight to EXEC
    exp_alu.push_back(alu_t'{4'h4, 16'hBEEF});
    send(mk(4'h4, 8'h00, 16'hBEEF), t_a);
    wait_idle(t_i);
    chk("sub_latency", t_i - t_a, 2 + ALU_DLY);
    chk("sub_alu_scalar", bus.alu_scalar, 16'hBEEF);
    chk("sub_loaded", bus.loaded, 1'b1);
    drained("sub");

    // Reset during LOAD element 12 (bank currently holds the SUM operands)
    pat = 0;
    push_load(8'h20);
    send(mk(c_op_load, 8'h20, 16'h0000), t_a);
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req && bus.mem_addr == 8'h2C) begin
        found = 1'b1;
        break;
      end
    end
    chk("midrst_found_elem12", found, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_mem_req", bus.mem_req, 1'b0);
    chk("midrst_loaded", bus.loaded, 1'b0);
    chk("midrst_err", bus.err, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_alu_op", bus.alu_op, 4'h0);
    chk("midrst_mat_a", bus.mat_a, '0);
    chk("midrst_mat_b", bus.mat_b, '0);
    exp_mem.delete();
    exp_alu.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fresh LOAD after reset
    pat = 1;
    push_load(8'h20);
    send(mk(c_op_load, 8'h20, 16'h0000), t_a);
    wait_idle(t_i);
    chk("reload_latency", t_i - t_a, 2 + 2*N2*(LAT+1));
    chk("reload_loaded", bus.loaded, 1'b1);
    check_bank("reload", 8'h20);
    drained("reload");

    // STORE base 0xF0, C[k] = 0x80+k, addresses wrap past 0xFF
    for (int k = 0; k < N2; k++) begin
      bus.mat_c[k*ELEM_W +: ELEM_W] = 8'(8'h80 + k);
      exp_mem.push_back(xfer_t'{1'b1, 8'(8'hF0 + 8'(k)), 8'(8'h80 + k)});
    end
    send(mk(c_op_store, 8'hF0, 16'h0000), t_a);
    wait_idle(t_i);
    chk("store_latency", t_i - t_a, 2 + N2*(LAT+1));
    drained("store");

    // Illegal opcodes set err with no side effect
    send(mk(4'hF, 8'h33, 16'h0000), t_a);
    wait_idle(t_i);
    chk("illegal_f_latency", t_i - t_a, 2);
    chk("illegal_f_err", bus.err, 1'b1);
    chk("illegal_f_loaded", bus.loaded, 1'b1);
    send(mk(4'h0, 8'h33, 16'h0000), t_a);
    wait_idle(t_i);
    chk("illegal_0_err", bus.err, 1'b1);
    drained("illegal");

    // A legal WRITE clears err
    exp_mem.push_back(xfer_t'{1'b1, 8'h01, 8'h42});
    send(mk(c_op_write, 8'h01, 16'h0042), t_a);
    wait_idle(t_i);
    chk("write3_err", bus.err, 1'b0);
    chk("write3_loaded", bus.loaded, 1'b0);
    drained("write3");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
